// File: rtl/div_unit_if.sv
// Execute-stage divider bus: issue side (operands, Rd, flush) and result/hazard side.
// The master modport is the pipeline, the slave modport is div_unit.
interface div_unit_if #(
   parameter int XLEN = 32
);
   logic            StartE;
   logic [1:0]      FunctE;
   logic [XLEN-1:0] SrcAE;
   logic [XLEN-1:0] SrcBE;
   logic [4:0]      RdE;
   logic            FlushE;
   logic            StallReqE;
   logic            ValidE;
   logic [XLEN-1:0] DivResultE;
   logic [4:0]      DivRdE;
   logic            BusyE;

   modport master (
      output StartE, FunctE, SrcAE, SrcBE, RdE, FlushE,
      input  StallReqE, ValidE, DivResultE, DivRdE, BusyE
   );

   modport slave (
      input  StartE, FunctE, SrcAE, SrcBE, RdE, FlushE,
      output StallReqE, ValidE, DivResultE, DivRdE, BusyE
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, with pipeline stall request.
// Optional macro DIV_FASTPATH_EN: divide-by-zero, signed overflow and |divisor|>|dividend| finish without iterating.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   div_unit_if.slave  div_if
);
   localparam int CNT_W = $clog2(XLEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      if (neg) begin
         return ~v + XLEN'(1);
      end else begin
         return v;
      end
   endfunction

   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] src_a_q, src_a_d;
   logic            sel_rem_q, sel_rem_d;
   logic [4:0]      rd_q, rd_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            div0_q, div0_d;
   logic            ovf_q, ovf_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      div_rd_q, div_rd_d;

   logic            is_signed_s;
   logic [XLEN-1:0] mag_a_s;
   logic [XLEN-1:0] mag_b_s;
   logic            div0_s;
   logic            ovf_s;
   logic [XLEN:0]   shift_s;
   logic [XLEN:0]   trial_s;
   logic            qbit_s;
   logic [XLEN-1:0] rem_next_s;
   logic [XLEN-1:0] quo_next_s;
   logic [XLEN-1:0] q_fin_s;
   logic [XLEN-1:0] r_fin_s;
   logic [XLEN-1:0] run_result_s;
   logic            last_iter_s;

   // Operand decode at issue: magnitudes and the architectural corner cases
   always_comb begin
      is_signed_s = ~div_if.FunctE[0];
      mag_a_s     = cond_neg(div_if.SrcAE, is_signed_s & div_if.SrcAE[XLEN-1]);
      mag_b_s     = cond_neg(div_if.SrcBE, is_signed_s & div_if.SrcBE[XLEN-1]);
      div0_s      = (div_if.SrcBE == {XLEN{1'b0}});
      ovf_s       = is_signed_s
                  & (div_if.SrcAE == {1'b1, {(XLEN-1){1'b0}}})
                  & (div_if.SrcBE == {XLEN{1'b1}});
   end

   // One restoring step: trial-subtract the divisor from {rem, next dividend bit}
   always_comb begin
      shift_s     = {rem_q, dvd_q[XLEN-1]};
      trial_s     = shift_s - {1'b0, dvs_q};
      qbit_s      = ~trial_s[XLEN];
      if (qbit_s) begin
         rem_next_s = trial_s[XLEN-1:0];
      end else begin
         rem_next_s = shift_s[XLEN-1:0];
      end
      quo_next_s  = {dvd_q[XLEN-2:0], qbit_s};
      last_iter_s = (cnt_q == CNT_W'(XLEN-1));
   end

   // Final sign fix on the last iteration's outputs; corner cases override the arithmetic
   always_comb begin
      if (div0_q) begin
         q_fin_s = {XLEN{1'b1}};
         r_fin_s = src_a_q;
      end else if (ovf_q) begin
         q_fin_s = {1'b1, {(XLEN-1){1'b0}}};
         r_fin_s = {XLEN{1'b0}};
      end else begin
         q_fin_s = cond_neg(quo_next_s, qneg_q);
         r_fin_s = cond_neg(rem_next_s, rneg_q);
      end
      if (sel_rem_q) begin
         run_result_s = r_fin_s;
      end else begin
         run_result_s = q_fin_s;
      end
   end

`ifdef DIV_FASTPATH_EN
   logic            fast_take_s;
   logic [XLEN-1:0] fast_result_s;

   // Results known at issue time, so the iterations can be skipped
   always_comb begin
      fast_take_s = div0_s | ovf_s | (mag_b_s > mag_a_s);
      if (div0_s) begin
         if (div_if.FunctE[1]) begin
            fast_result_s = div_if.SrcAE;
         end else begin
            fast_result_s = {XLEN{1'b1}};
         end
      end else if (ovf_s) begin
         if (div_if.FunctE[1]) begin
            fast_result_s = {XLEN{1'b0}};
         end else begin
            fast_result_s = {1'b1, {(XLEN-1){1'b0}}};
         end
      end else begin
         if (div_if.FunctE[1]) begin
            fast_result_s = div_if.SrcAE;
         end else begin
            fast_result_s = {XLEN{1'b0}};
         end
      end
   end
`endif

   // Next-state logic; a flush squashes the instruction from any state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      src_a_d   = src_a_q;
      sel_rem_d = sel_rem_q;
      rd_d      = rd_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      result_d  = result_q;
      div_rd_d  = div_rd_q;
      if (div_if.FlushE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (div_if.StartE) begin
                  sel_rem_d = div_if.FunctE[1];
                  rd_d      = div_if.RdE;
                  dvd_d     = mag_a_s;
                  dvs_d     = mag_b_s;
                  src_a_d   = div_if.SrcAE;
                  qneg_d    = is_signed_s & (div_if.SrcAE[XLEN-1] ^ div_if.SrcBE[XLEN-1]);
                  rneg_d    = is_signed_s & div_if.SrcAE[XLEN-1];
                  div0_d    = div0_s;
                  ovf_d     = ovf_s;
                  rem_d     = {XLEN{1'b0}};
                  cnt_d     = {CNT_W{1'b0}};
`ifdef DIV_FASTPATH_EN
                  if (fast_take_s) begin
                     state_d  = ST_DONE;
                     result_d = fast_result_s;
                     div_rd_d = div_if.RdE;
                  end else begin
                     state_d  = ST_RUN;
                  end
`else
                  state_d   = ST_RUN;
`endif
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               rem_d = rem_next_s;
               dvd_d = quo_next_s;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter_s) begin
                  state_d  = ST_DONE;
                  result_d = run_result_s;
                  div_rd_d = rd_q;
               end else begin
                  state_d  = ST_RUN;
               end
            end
            ST_DONE: begin
               // The instruction in EX is the one just finished, so StartE is ignored
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         dvd_q     <= {XLEN{1'b0}};
         rem_q     <= {XLEN{1'b0}};
         dvs_q     <= {XLEN{1'b0}};
         src_a_q   <= {XLEN{1'b0}};
         sel_rem_q <= 1'b0;
         rd_q      <= 5'd0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         result_q  <= {XLEN{1'b0}};
         div_rd_q  <= 5'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         src_a_q   <= src_a_d;
         sel_rem_q <= sel_rem_d;
         rd_q      <= rd_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
         result_q  <= result_d;
         div_rd_q  <= div_rd_d;
      end
   end

   // Stall is raised in the issue cycle itself so F/D hold before RUN begins
   always_comb begin
      div_if.StallReqE  = ((state_q == ST_IDLE) & div_if.StartE & ~div_if.FlushE)
                        | (state_q == ST_RUN);
      div_if.ValidE     = (state_q == ST_DONE) & ~div_if.FlushE;
      div_if.BusyE      = (state_q != ST_IDLE);
      div_if.DivResultE = result_q;
      div_if.DivRdE     = div_rd_q;
   end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus flush, reset and back-to-back sequences.
module tb_div_unit;
   localparam logic [1:0] F_DIV  = 2'b00;
   localparam logic [1:0] F_DIVU = 2'b01;
   localparam logic [1:0] F_REM  = 2'b10;
   localparam logic [1:0] F_REMU = 2'b11;
   localparam int LN = 33;
`ifdef DIV_FASTPATH_EN
   localparam int LF = 1;
`else
   localparam int LF = 33;
`endif

   typedef struct {
      logic [1:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
      string       name;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int checks = 0;
   int errors = 0;
   vec_t vecs[20];
   logic [31:0] last_res;

   div_unit_if bus ();

   div_unit dut (
      .clk    (clk),
      .reset_n(reset_n),
      .div_if (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called shortly after a rising edge; issues one op and follows it to ValidE.
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                         input string name);
      int cyc;
      int stall_cnt;
      bit seen;
      bus.StartE = 1'b1;
      bus.FunctE = f;
      bus.SrcAE  = a;
      bus.SrcBE  = b;
      bus.RdE    = rd;
      #1;
      check({name, " stall0"}, 32'(bus.StallReqE), 32'd1);
      cyc = 0;
      stall_cnt = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge clk);
         #1;
         bus.StartE = 1'b0;
         #1;
         cyc++;
         if (bus.ValidE) begin
            seen = 1'b1;
         end else if (bus.StallReqE) begin
            stall_cnt++;
         end
      end
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " result"}, bus.DivResultE, exp_res);
      check({name, " rd"}, 32'(bus.DivRdE), 32'(rd));
      check({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat - 1));
      check({name, " stall in done"}, 32'(bus.StallReqE), 32'd0);
      @(posedge clk);
      #1;
      check({name, " idle after"}, 32'(bus.BusyE), 32'd0);
   endtask

   initial begin
      bus.StartE = 1'b0;
      bus.FunctE = 2'b00;
      bus.SrcAE  = 32'd0;
      bus.SrcBE  = 32'd0;
      bus.RdE    = 5'd0;
      bus.FlushE = 1'b0;

      vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         LN, "divu 100/7"};
      vecs[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          LN, "remu 100/7"};
      vecs[2]  = '{F_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   LN, "div -100/7"};
      vecs[3]  = '{F_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   LN, "rem -100/7"};
      vecs[4]  = '{F_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   LN, "div 100/-7"};
      vecs[5]  = '{F_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          LN, "rem 100/-7"};
      vecs[6]  = '{F_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LF, "div ovf"};
      vecs[7]  = '{F_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          LF, "rem ovf"};
      vecs[8]  = '{F_DIVU, 32'h00001234,   32'd0,          32'hFFFFFFFF,   LF, "divu by 0"};
      vecs[9]  = '{F_REMU, 32'h00001234,   32'd0,          32'h00001234,   LF, "remu by 0"};
      vecs[10] = '{F_DIV,  32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   LF, "div -100/0"};
      vecs[11] = '{F_REM,  32'hFFFFFF9C,   32'd0,          32'hFFFFFF9C,   LF, "rem -100/0"};
      vecs[12] = '{F_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   LN, "divu max/1"};
      vecs[13] = '{F_DIVU, 32'd7,          32'd100,        32'd0,          LF, "divu 7/100"};
      vecs[14] = '{F_REMU, 32'd7,          32'd100,        32'd7,          LF, "remu 7/100"};
      vecs[15] = '{F_REM,  32'hFFFFFFF9,   32'd100,        32'hFFFFFFF9,   LF, "rem -7/100"};
      vecs[16] = '{F_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          LN, "div -7/-2"};
      vecs[17] = '{F_REM,  32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   LN, "rem -7/-2"};
      vecs[18] = '{F_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   LF, "remu min/max"};
      vecs[19] = '{F_DIVU, 32'd1000000,    32'd1000,       32'd1000,       LN, "divu 1e6/1e3"};

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("reset valid", 32'(bus.ValidE), 32'd0);
      check("reset busy", 32'(bus.BusyE), 32'd0);
      check("reset stall", 32'(bus.StallReqE), 32'd0);
      check("reset result", bus.DivResultE, 32'd0);
      check("reset rd", 32'(bus.DivRdE), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res, vecs[i].lat, vecs[i].name);
      end
      last_res = vecs[19].res;

      // Flush at cycle 10 of a divide, then a new op at cycle 11
      begin
         bit valid_seen;
         valid_seen = 1'b0;
         bus.StartE = 1'b1;
         bus.FunctE = F_DIVU;
         bus.SrcAE  = 32'd1000;
         bus.SrcBE  = 32'd3;
         bus.RdE    = 5'd9;
         #1;
         for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            bus.StartE = 1'b0;
            bus.FlushE = (c == 10);
            #1;
            if (bus.ValidE) valid_seen = 1'b1;
         end
         check("flush stall at c10", 32'(bus.StallReqE), 32'd1);
         @(posedge clk);
         #1;
         bus.FlushE = 1'b0;
         #1;
         check("flush no valid", 32'(valid_seen | bus.ValidE), 32'd0);
         check("flush idle c11", 32'(bus.BusyE), 32'd0);
         check("flush result held", bus.DivResultE, last_res);
         check("flush rd held", 32'(bus.DivRdE), 32'd20);
         run_op(F_DIVU, 32'd9, 32'd3, 5'd11, 32'd3, LN, "after flush 9/3");
      end

      // Asynchronous reset in cycle 20 of a divide
      bus.StartE = 1'b1;
      bus.FunctE = F_DIVU;
      bus.SrcAE  = 32'd500;
      bus.SrcBE  = 32'd7;
      bus.RdE    = 5'd12;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         bus.StartE = 1'b0;
      end
      #1;
      check("busy before reset", 32'(bus.BusyE), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async rst busy", 32'(bus.BusyE), 32'd0);
      check("async rst stall", 32'(bus.StallReqE), 32'd0);
      check("async rst valid", 32'(bus.ValidE), 32'd0);
      check("async rst result", bus.DivResultE, 32'd0);
      check("async rst rd", 32'(bus.DivRdE), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op(F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, LN, "after reset");

      // Back-to-back ops at cycles 0 and 34; StartE stays high through both DONE cycles
      for (int c = 0; c <= 70; c++) begin
         logic exp_v;
         logic exp_s;
         logic exp_b;
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         bus.StartE = (c <= 67);
         bus.FunctE = F_DIVU;
         bus.SrcAE  = (c < 34) ? 32'd50 : 32'd81;
         bus.SrcBE  = (c < 34) ? 32'd5 : 32'd9;
         bus.RdE    = (c < 34) ? 5'd3 : 5'd4;
         #1;
         exp_v = (c == 33) || (c == 67);
         exp_s = (c <= 32) || (c >= 34 && c <= 66);
         exp_b = (c >= 1 && c <= 33) || (c >= 35 && c <= 67);
         check($sformatf("b2b valid c%0d", c), 32'(bus.ValidE), 32'(exp_v));
         check($sformatf("b2b stall c%0d", c), 32'(bus.StallReqE), 32'(exp_s));
         check($sformatf("b2b busy c%0d", c), 32'(bus.BusyE), 32'(exp_b));
         if (c == 33) begin
            check("b2b first result", bus.DivResultE, 32'd10);
            check("b2b first rd", 32'(bus.DivRdE), 32'd3);
         end
         if (c == 67) begin
            check("b2b second result", bus.DivResultE, 32'd9);
            check("b2b second rd", 32'(bus.DivRdE), 32'd4);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, placed in the Execute stage beside the ALU. It is the stall-requesting end of the pipeline's hazard control. While a division is in flight it holds StallReqE high, and the hazard unit ORs this into StallF/StallD and holds the E/M boundary. It takes FlushE from the hazard unit to abort work on a squashed instruction.

## Interface
- XLEN, 32, operand and result width; counter width is $clog2(XLEN)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- StartE  in  1  EX-stage instruction is a divide/remainder op
- FunctE  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- SrcAE  in  XLEN  dividend (forwarded operand A)
- SrcBE  in  XLEN  divisor (forwarded operand B)
- RdE  in  5  destination register of the EX instruction
- FlushE  in  1  kill EX instruction (branch taken); aborts any operation
- StallReqE  out  1  hold pipeline; combinational
- ValidE  out  1  one-cycle pulse: DivResultE is final
- DivResultE  out  XLEN  quotient or remainder
- DivRdE  out  5  Rd captured at start
- BusyE  out  1  state is not IDLE

## Operation
- States:
  - IDLE: accept start.
  - RUN: one iteration per cycle.
  - DONE: present the result for one cycle, then go to IDLE.
- IDLE + StartE + !FlushE:
  - Latch FunctE and RdE.
  - Latch the magnitudes of SrcAE/SrcBE. Two's-complement absolute value applies for DIV/REM; operands are taken raw for DIVU/REMU.
  - Latch the result signs: quotient negative = signA ^ signB; remainder negative = signA.
  - Clear the partial remainder and the 5-bit counter, then go to RUN.
- RUN, each cycle:
  - Form the 33-bit trial value {rem, dividend_msb} - divisor.
  - If it is non-negative, rem takes the difference and quotient bit = 1; otherwise rem takes the shifted value and quotient bit = 0.
  - Shift the dividend/quotient register left by one and increment the counter.
  - After iteration XLEN (counter wraps 31→0), go to DONE.
- DONE:
  - Apply the sign fix and select quotient or remainder; register the result into DivResultE.
  - ValidE=1 and StallReqE=0, so the instruction advances to M with the result.
  - StartE is ignored here; the same instruction is still in EX.
  - Next state is IDLE.
- Spec corner cases override the computed value:
  - Divisor 0: Q = all ones, R = dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: Q = 0x80000000, R = 0.
- StallReqE = (IDLE & StartE & !FlushE) | RUN.
- FlushE has priority in every state. The next state is IDLE, ValidE stays 0, and no result is produced.
- The hazard unit must not assert FlushE for a load-use bubble while StallReqE is high. D is already held in that case.
- DivResultE and DivRdE hold their values until the next DONE.

## Timing
- Reset: state IDLE; StallReqE, ValidE, BusyE = 0; DivResultE = 0; DivRdE = 0; counter = 0. Reset mid-operation discards the operation.
- Normal latency:
  - Start is seen in cycle 0, and StallReqE is high in cycle 0 itself.
  - RUN occupies cycles 1–32.
  - DONE is cycle 33, with ValidE=1 and StallReqE=0.
  - The instruction leaves EX at the end of cycle 33, for 34 cycles in EX in total.
- A back-to-back divide entering EX in cycle 34 finds IDLE and is accepted.
- A flush in cycle k aborts at the end of cycle k. A new StartE in cycle k+1 is accepted.
- BusyE is high in RUN and DONE.

## Configuration
- DIV_FASTPATH_EN defined:
  - Divide-by-zero and signed overflow are detected in IDLE and go straight to DONE, skipping RUN.
  - Result is in cycle 1; StallReqE is high in cycle 0 only.
  - Divisor magnitude > dividend magnitude (Q=0, R=dividend) also takes the fast path.
- Undefined: every operation runs the full 32 iterations. The corner cases are still correct via the override in DONE. Latency is a constant 34 cycles.

## Test plan
- DIVU 100/7, RdE=5 -> StallReqE cycles 0–32, ValidE at cycle 33, DivResultE=14, DivRdE=5; REMU same operands -> 2.
- DIV 0xFFFFFF9C(-100)/7 -> 0xFFFFFFF2(-14); REM -> 0xFFFFFFFE(-2); DIV 100/0xFFFFFFF9 -> 0xFFFFFFF2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. DIVU 0x1234/0 -> 0xFFFFFFFF, REMU -> 0x1234. Both at cycle 33 without the macro, cycle 1 with it.
- Start DIVU, FlushE at cycle 10 -> IDLE at cycle 11, ValidE never pulses. New DIVU 9/3 at cycle 11 -> result 3 at cycle 44.
- reset_n low at cycle 20 of a divide -> all outputs 0 immediately (asynchronous). After release, StartE is accepted on the first clock.
- Two consecutive DIVU ops (cycles 0 and 34) -> two ValidE pulses at cycles 33 and 67. StartE held high during DONE does not start a third op.
